// File: rtl/radix_4_operand_loader_pkg.sv
// rtl/radix_4_operand_loader_pkg.sv - shared widths, stage size and mode encoding for the radix-4 loader
package radix_4_operand_loader_pkg;

  // Coefficient/twiddle width matches radix_2_parameter.vh
  localparam int RADIX_WIDTH    = 32;
  localparam int RADIX_N_GROUPS = 64;
  localparam int RADIX_GIDX_W   = 6;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/radix_4_group_fifo.sv
// rtl/radix_4_group_fifo.sv - two-entry register FIFO holding assembled butterfly groups
module radix_4_group_fifo
  import radix_4_operand_loader_pkg::*;
#(
  parameter int ENTRY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head_data,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               do_push;
  logic               do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage is zeroed only by reset; clear just drops occupancy and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/radix_4_operand_loader.sv
// rtl/radix_4_operand_loader.sv - assembles serial coefficients into radix-4 butterfly operand groups
module radix_4_operand_loader
  import radix_4_operand_loader_pkg::*;
#(
  parameter int width    = RADIX_WIDTH,
  parameter int N_GROUPS = RADIX_N_GROUPS,
  parameter int GIDX_W   = RADIX_GIDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [width-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [width-1:0]  in_twiddle_1,
  input  logic [width-1:0]  in_twiddle_2,
  input  logic [width-1:0]  in_twiddle_3,
  input  logic              in_select,
  output logic [width-1:0]  output_1,
  output logic [width-1:0]  output_2,
  output logic [width-1:0]  output_3,
  output logic [width-1:0]  output_4,
  output logic [width-1:0]  output_twiddle_1,
  output logic [width-1:0]  output_twiddle_2,
  output logic [width-1:0]  output_twiddle_3,
  output logic              output_select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GIDX_W-1:0] group_index,
  output logic              last_group,
  output logic              stage_done
);

  typedef struct packed {
    logic [width-1:0]  lane_0;
    logic [width-1:0]  lane_1;
    logic [width-1:0]  lane_2;
    logic [width-1:0]  lane_3;
    logic [width-1:0]  twiddle_1;
    logic [width-1:0]  twiddle_2;
    logic [width-1:0]  twiddle_3;
    logic              select;
    logic [GIDX_W-1:0] gidx;
    logic              last;
  } group_t;

  logic [1:0]        lane_cnt;
  logic [width-1:0]  lane_0;
  logic [width-1:0]  lane_1;
  logic [width-1:0]  lane_2;
  logic [GIDX_W-1:0] wr_gidx;
  logic              wr_last;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  group_t            push_group;
  group_t            head_group;

  // in_ready depends only on state so the butterfly's out_ready never loops back.
  assign in_ready  = !((lane_cnt == 2'd3) && fifo_full);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (lane_cnt == 2'd3);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign wr_last   = (wr_gidx == GIDX_W'(N_GROUPS - 1));

  always_comb begin
    push_group           = '0;
    push_group.lane_0    = lane_0;
    push_group.lane_1    = lane_1;
    push_group.lane_2    = lane_2;
    push_group.lane_3    = in_data;
    push_group.twiddle_1 = in_twiddle_1;
    push_group.twiddle_2 = in_twiddle_2;
    push_group.twiddle_3 = in_twiddle_3;
    push_group.select    = in_select;
    push_group.gidx      = wr_gidx;
    push_group.last      = wr_last;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_cnt   <= 2'd0;
      lane_0     <= '0;
      lane_1     <= '0;
      lane_2     <= '0;
      wr_gidx    <= '0;
      stage_done <= 1'b0;
    end else if (clear) begin
      lane_cnt   <= 2'd0;
      wr_gidx    <= '0;
      stage_done <= 1'b0;
    end else begin
      if (accept) begin
        lane_cnt <= lane_cnt + 2'd1;
        case (lane_cnt)
          2'd0:    lane_0 <= in_data;
          2'd1:    lane_1 <= in_data;
          2'd2:    lane_2 <= in_data;
          default: lane_0 <= lane_0;
        endcase
      end
      if (push) begin
        wr_gidx <= wr_last ? '0 : wr_gidx + GIDX_W'(1);
      end
      stage_done <= pop && head_group.last;
    end
  end

  radix_4_group_fifo #(
    .ENTRY_W($bits(group_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (push_group),
    .pop       (pop),
    .head_data (head_group),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign output_1         = head_group.lane_0;
  assign output_2         = head_group.lane_1;
  assign output_3         = head_group.lane_2;
  assign output_4         = head_group.lane_3;
  assign output_twiddle_1 = head_group.twiddle_1;
  assign output_twiddle_2 = head_group.twiddle_2;
  assign output_twiddle_3 = head_group.twiddle_3;
  assign output_select    = head_group.select;
  assign group_index      = head_group.gidx;
  assign last_group       = head_group.last;

endmodule

// File: tb/tb_radix_4_operand_loader.sv
// tb/tb_radix_4_operand_loader.sv - directed scenario bench for radix_4_operand_loader
module tb_radix_4_operand_loader;

  localparam int W  = 32;
  localparam int NG = 4;
  localparam int GW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_twiddle_1 = '0;
  logic [W-1:0]  in_twiddle_2 = '0;
  logic [W-1:0]  in_twiddle_3 = '0;
  logic          in_select = 1'b0;
  logic [W-1:0]  output_1, output_2, output_3, output_4;
  logic [W-1:0]  output_twiddle_1, output_twiddle_2, output_twiddle_3;
  logic          output_select;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [GW-1:0] group_index;
  logic          last_group;
  logic          stage_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  radix_4_operand_loader #(.width(W), .N_GROUPS(NG), .GIDX_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_twiddle_1(in_twiddle_1), .in_twiddle_2(in_twiddle_2), .in_twiddle_3(in_twiddle_3),
    .in_select(in_select),
    .output_1(output_1), .output_2(output_2), .output_3(output_3), .output_4(output_4),
    .output_twiddle_1(output_twiddle_1), .output_twiddle_2(output_twiddle_2),
    .output_twiddle_3(output_twiddle_3), .output_select(output_select),
    .out_valid(out_valid), .out_ready(out_ready),
    .group_index(group_index), .last_group(last_group), .stage_done(stage_done)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dut.u_fifo.count > 2'd2) begin
        failures++;
        $display("FAIL fifo_count_bound got=%0d exp<=2", dut.u_fifo.count);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic [W-1:0] t1, input logic [W-1:0] t2,
                           input logic [W-1:0] t3, input logic sel);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_data = d;
    in_twiddle_1 = t1; in_twiddle_2 = t2; in_twiddle_3 = t3; in_select = sel;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_word_timeout got=%0b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (stage_done !== 1'b0) begin failures++; $display("FAIL reset_stage_done got=%0b exp=0", stage_done); end
    checks++; if (output_1 !== 32'd0) begin failures++; $display("FAIL reset_output_1 got=%0d exp=0", output_1); end
    checks++; if (output_twiddle_1 !== 32'd0) begin failures++; $display("FAIL reset_twiddle_1 got=%0d exp=0", output_twiddle_1); end
    checks++; if (output_select !== 1'b0) begin failures++; $display("FAIL reset_select got=%0b exp=0", output_select); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (group_index !== 6'd0) begin failures++; $display("FAIL reset_group_index got=%0d exp=0", group_index); end
  endtask

  task automatic test_basic_load();
    do_clear();
    out_ready = 1'b1;
    send_word(32'd1, 32'd99, 32'd99, 32'd99, 1'b1);
    send_word(32'd2, 32'd99, 32'd99, 32'd99, 1'b1);
    send_word(32'd3, 32'd99, 32'd99, 32'd99, 1'b1);
    send_word(32'd4, 32'd10, 32'd20, 32'd30, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0b exp=1", out_valid); end
    checks++; if (output_1 !== 32'd1) begin failures++; $display("FAIL basic_output_1 got=%0d exp=1", output_1); end
    checks++; if (output_2 !== 32'd2) begin failures++; $display("FAIL basic_output_2 got=%0d exp=2", output_2); end
    checks++; if (output_3 !== 32'd3) begin failures++; $display("FAIL basic_output_3 got=%0d exp=3", output_3); end
    checks++; if (output_4 !== 32'd4) begin failures++; $display("FAIL basic_output_4 got=%0d exp=4", output_4); end
    checks++; if (output_twiddle_1 !== 32'd10) begin failures++; $display("FAIL basic_tw1 got=%0d exp=10", output_twiddle_1); end
    checks++; if (output_twiddle_2 !== 32'd20) begin failures++; $display("FAIL basic_tw2 got=%0d exp=20", output_twiddle_2); end
    checks++; if (output_twiddle_3 !== 32'd30) begin failures++; $display("FAIL basic_tw3 got=%0d exp=30", output_twiddle_3); end
    checks++; if (output_select !== 1'b0) begin failures++; $display("FAIL basic_select got=%0b exp=0", output_select); end
    checks++; if (group_index !== 6'd0) begin failures++; $display("FAIL basic_group_index got=%0d exp=0", group_index); end
    checks++; if (last_group !== 1'b0) begin failures++; $display("FAIL basic_last_group got=%0b exp=0", last_group); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%0b exp=0", out_valid); end
    checks++; if (stage_done !== 1'b0) begin failures++; $display("FAIL basic_stage_done got=%0b exp=0", stage_done); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_clear();
    out_ready = 1'b0;
    for (int w = 1; w <= 11; w++) begin
      in_valid = 1'b1; in_data = 100 + w;
      in_twiddle_1 = 1000 + w; in_twiddle_2 = 2000 + w; in_twiddle_3 = 3000 + w; in_select = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_w%0d got=%0b exp=1", w, in_ready); end
      tick();
    end
    in_data = 32'd112; in_twiddle_1 = 32'd1012; in_twiddle_2 = 32'd2012; in_twiddle_3 = 32'd3012;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_w12 got=%0b exp=0", in_ready); end
    checks++; if (dut.u_fifo.count !== 2'd2) begin failures++; $display("FAIL bp_count_full got=%0d exp=2", dut.u_fifo.count); end
    checks++; if (output_1 !== 32'd101) begin failures++; $display("FAIL bp_g0_output_1 got=%0d exp=101", output_1); end
    checks++; if (output_4 !== 32'd104) begin failures++; $display("FAIL bp_g0_output_4 got=%0d exp=104", output_4); end
    checks++; if (output_twiddle_1 !== 32'd1004) begin failures++; $display("FAIL bp_g0_tw1 got=%0d exp=1004", output_twiddle_1); end
    checks++; if (group_index !== 6'd0) begin failures++; $display("FAIL bp_g0_index got=%0d exp=0", group_index); end
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after_pop got=%0b exp=1", in_ready); end
    checks++; if (output_1 !== 32'd105) begin failures++; $display("FAIL bp_g1_output_1 got=%0d exp=105", output_1); end
    checks++; if (output_4 !== 32'd108) begin failures++; $display("FAIL bp_g1_output_4 got=%0d exp=108", output_4); end
    checks++; if (group_index !== 6'd1) begin failures++; $display("FAIL bp_g1_index got=%0d exp=1", group_index); end
    tick();
    in_valid = 1'b0;
    checks++; if (dut.u_fifo.count !== 2'd1) begin failures++; $display("FAIL bp_count_pushpop got=%0d exp=1", dut.u_fifo.count); end
    checks++; if (output_1 !== 32'd109) begin failures++; $display("FAIL bp_g2_output_1 got=%0d exp=109", output_1); end
    checks++; if (output_4 !== 32'd112) begin failures++; $display("FAIL bp_g2_output_4 got=%0d exp=112", output_4); end
    checks++; if (output_twiddle_3 !== 32'd3012) begin failures++; $display("FAIL bp_g2_tw3 got=%0d exp=3012", output_twiddle_3); end
    checks++; if (group_index !== 6'd2) begin failures++; $display("FAIL bp_g2_index got=%0d exp=2", group_index); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_clear();
    out_ready = 1'b0;
    send_word(32'd201, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd202, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd203, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd204, 32'd7, 32'd8, 32'd9, 1'b1);
    checks++; if (dut.u_fifo.count !== 2'd1) begin failures++; $display("FAIL sim_count_a got=%0d exp=1", dut.u_fifo.count); end
    checks++; if (output_select !== 1'b1) begin failures++; $display("FAIL sim_a_select got=%0b exp=1", output_select); end
    send_word(32'd205, 32'd0, 32'd0, 32'd0, 1'b1);
    send_word(32'd206, 32'd0, 32'd0, 32'd0, 1'b1);
    send_word(32'd207, 32'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (output_1 !== 32'd201) begin failures++; $display("FAIL sim_a_stable got=%0d exp=201", output_1); end
    in_valid = 1'b1; in_data = 32'd208; in_twiddle_1 = 32'd17; in_twiddle_2 = 32'd18; in_twiddle_3 = 32'd19; in_select = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (dut.u_fifo.count !== 2'd1) begin failures++; $display("FAIL sim_count_b got=%0d exp=1", dut.u_fifo.count); end
    checks++; if (output_1 !== 32'd205) begin failures++; $display("FAIL sim_b_output_1 got=%0d exp=205", output_1); end
    checks++; if (output_2 !== 32'd206) begin failures++; $display("FAIL sim_b_output_2 got=%0d exp=206", output_2); end
    checks++; if (output_3 !== 32'd207) begin failures++; $display("FAIL sim_b_output_3 got=%0d exp=207", output_3); end
    checks++; if (output_4 !== 32'd208) begin failures++; $display("FAIL sim_b_output_4 got=%0d exp=208", output_4); end
    checks++; if (output_twiddle_2 !== 32'd18) begin failures++; $display("FAIL sim_b_tw2 got=%0d exp=18", output_twiddle_2); end
    checks++; if (output_select !== 1'b0) begin failures++; $display("FAIL sim_b_select got=%0b exp=0", output_select); end
    checks++; if (group_index !== 6'd1) begin failures++; $display("FAIL sim_b_index got=%0d exp=1", group_index); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sim_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_stage_wrap();
    do_clear();
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      for (int l = 0; l < 4; l++) begin
        send_word(300 + 4*g + l + 1, 50 + g, 60 + g, 70 + g, (g >= 2));
      end
      checks++; if (group_index !== GW'(g)) begin failures++; $display("FAIL wrap_index_g%0d got=%0d exp=%0d", g, group_index, g); end
      checks++; if (last_group !== (g == 3)) begin failures++; $display("FAIL wrap_last_g%0d got=%0b exp=%0b", g, last_group, (g == 3)); end
      checks++; if (output_select !== (g >= 2)) begin failures++; $display("FAIL wrap_select_g%0d got=%0b exp=%0b", g, output_select, (g >= 2)); end
      checks++; if (output_1 !== W'(300 + 4*g + 1)) begin failures++; $display("FAIL wrap_output_1_g%0d got=%0d exp=%0d", g, output_1, 300 + 4*g + 1); end
      checks++; if (output_4 !== W'(300 + 4*g + 4)) begin failures++; $display("FAIL wrap_output_4_g%0d got=%0d exp=%0d", g, output_4, 300 + 4*g + 4); end
      checks++; if (output_twiddle_1 !== W'(50 + g)) begin failures++; $display("FAIL wrap_tw1_g%0d got=%0d exp=%0d", g, output_twiddle_1, 50 + g); end
      checks++; if (stage_done !== 1'b0) begin failures++; $display("FAIL wrap_early_done_g%0d got=%0b exp=0", g, stage_done); end
    end
    tick();
    checks++; if (stage_done !== 1'b1) begin failures++; $display("FAIL wrap_stage_done got=%0b exp=1", stage_done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drained got=%0b exp=0", out_valid); end
    tick();
    checks++; if (stage_done !== 1'b0) begin failures++; $display("FAIL wrap_done_width got=%0b exp=0", stage_done); end
    send_word(32'd401, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd402, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd403, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd404, 32'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (group_index !== 6'd0) begin failures++; $display("FAIL wrap_restart_index got=%0d exp=0", group_index); end
    checks++; if (last_group !== 1'b0) begin failures++; $display("FAIL wrap_restart_last got=%0b exp=0", last_group); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_clear();
    out_ready = 1'b1;
    send_word(32'd901, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd902, 32'd0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%0b exp=0", out_valid); end
    checks++; if (output_1 !== 32'd0) begin failures++; $display("FAIL rmid_output_1 got=%0d exp=0", output_1); end
    checks++; if (output_4 !== 32'd0) begin failures++; $display("FAIL rmid_output_4 got=%0d exp=0", output_4); end
    checks++; if (output_twiddle_2 !== 32'd0) begin failures++; $display("FAIL rmid_tw2 got=%0d exp=0", output_twiddle_2); end
    checks++; if (output_select !== 1'b0) begin failures++; $display("FAIL rmid_select got=%0b exp=0", output_select); end
    checks++; if (stage_done !== 1'b0) begin failures++; $display("FAIL rmid_stage_done got=%0b exp=0", stage_done); end
    rst_n = 1'b1;
    send_word(32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd6, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd7, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd8, 32'd11, 32'd22, 32'd33, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_new_valid got=%0b exp=1", out_valid); end
    checks++; if (output_1 !== 32'd5) begin failures++; $display("FAIL rmid_new_output_1 got=%0d exp=5", output_1); end
    checks++; if (output_2 !== 32'd6) begin failures++; $display("FAIL rmid_new_output_2 got=%0d exp=6", output_2); end
    checks++; if (output_3 !== 32'd7) begin failures++; $display("FAIL rmid_new_output_3 got=%0d exp=7", output_3); end
    checks++; if (output_4 !== 32'd8) begin failures++; $display("FAIL rmid_new_output_4 got=%0d exp=8", output_4); end
    checks++; if (output_twiddle_3 !== 32'd33) begin failures++; $display("FAIL rmid_new_tw3 got=%0d exp=33", output_twiddle_3); end
    checks++; if (group_index !== 6'd0) begin failures++; $display("FAIL rmid_new_index got=%0d exp=0", group_index); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clear_priority();
    do_clear();
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      send_word(500 + i, 0, 0, 0, 1'b0);
    end
    tick();
    out_ready = 1'b0;
    send_word(32'd601, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd602, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd603, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd604, 32'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (last_group !== 1'b1) begin failures++; $display("FAIL clr_head_last got=%0b exp=1", last_group); end
    checks++; if (group_index !== 6'd3) begin failures++; $display("FAIL clr_head_index got=%0d exp=3", group_index); end
    send_word(32'd605, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd606, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd607, 32'd0, 32'd0, 32'd0, 1'b0);
    in_valid = 1'b1; in_data = 32'd608; out_ready = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_out_valid got=%0b exp=0", out_valid); end
    checks++; if (dut.u_fifo.count !== 2'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", dut.u_fifo.count); end
    checks++; if (stage_done !== 1'b0) begin failures++; $display("FAIL clr_stage_done got=%0b exp=0", stage_done); end
    tick();
    checks++; if (stage_done !== 1'b0) begin failures++; $display("FAIL clr_stage_done_late got=%0b exp=0", stage_done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_out_valid_late got=%0b exp=0", out_valid); end
    send_word(32'd701, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd702, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd703, 32'd0, 32'd0, 32'd0, 1'b0);
    send_word(32'd704, 32'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (output_1 !== 32'd701) begin failures++; $display("FAIL clr_next_output_1 got=%0d exp=701", output_1); end
    checks++; if (output_4 !== 32'd704) begin failures++; $display("FAIL clr_next_output_4 got=%0d exp=704", output_4); end
    checks++; if (group_index !== 6'd0) begin failures++; $display("FAIL clr_next_index got=%0d exp=0", group_index); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_simultaneous();
    test_stage_wrap();
    test_reset_mid();
    test_clear_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
